eaglesong_perm_engine: RTL and testbench
========================================

Name: eaglesong_perm_engine

Overview:
- Clocked, handshaked Eaglesong permutation engine.
- Applies NUM_ROUNDS rounds to a 16x32-bit state, unrolling ROUNDS_PER_CYCLE rounds per clock.
- Successor to the single-round combinational permutation: it adds an internal round counter, valid/ready flow control and configurable area/latency.
- Sits between the absorb/squeeze sponge controller and the state register file.

Parameters:
- NUM_ROUNDS, 43: total rounds per permutation (1..43).
- ROUNDS_PER_CYCLE, 1: rounds evaluated per clock (1..NUM_ROUNDS).
- FIRST_ROUND, 0: index of first injection-constant row used (FIRST_ROUND+NUM_ROUNDS <= 43).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_state valid
- in_ready  out  1  engine accepts in_state this cycle
- in_state  in  16x32  input state words [15:0]
- out_valid  out  1  out_state holds a finished permutation
- out_ready  in  1  consumer takes out_state
- out_state  out  16x32  permuted state
- busy  out  1  high in RUN

Behaviour:
- Reset values: state=IDLE, out_valid=0, busy=0, out_state=all zero, round counter=0.
- The reset/polarity line is fixed: one clock, clk; rst is synchronous, active-high.
- FSM IDLE -> RUN -> DONE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready loads in_state into the state register, sets rnd=FIRST_ROUND, and moves to RUN.
- RUN:
  - Each cycle applies k=min(ROUNDS_PER_CYCLE, FIRST_ROUND+NUM_ROUNDS-rnd) rounds, then rnd+=k.
  - When rnd reaches FIRST_ROUND+NUM_ROUNDS, the result is registered and the FSM moves to DONE.
  - Unused unrolled stages in the final partial cycle are bypassed and pass state through unchanged.
  - in_ready=0.
- DONE:
  - out_valid=1; out_state is stable while out_ready=0.
  - out_valid&out_ready -> IDLE.
  - in_ready=out_ready in DONE. A simultaneous in_valid loads the new state and goes straight to RUN (back-to-back, no bubble).
- Latency: ceil(NUM_ROUNDS/ROUNDS_PER_CYCLE) cycles from the accept edge to out_valid. Examples: 43 at R=1, 11 at R=4, 1 at R=43.
- Round r on state s (all arithmetic mod 2^32, rotl is left-rotate):
  1. Bit matrix: t[j] = XOR over k of (BIT_MATRIX[k][j] ? s[k] : 0).
  2. Circulant: t[i] ^= rotl(t[i],COEF[i][1]) ^ rotl(t[i],COEF[i][2]).
  3. Injection: t[i] ^= INJECT[r][i].
  4. ARX, for even i:
     - t[i] += t[i+1]; t[i] = rotl(t[i],8);
     - t[i+1] = rotl(t[i+1],24); t[i+1] += t[i].
- in_state is sampled only on the accept edge. Changes to in_state during RUN have no effect.
- rst in any state, including mid-RUN, aborts the operation: state returns to IDLE and out_valid clears on the next edge. The partial result is discarded.
- in_valid while busy is ignored; there is no queueing.

Optional Feature:
- Macro: EAGLESONG_PERM_DBG_PORT_EN.
- Defined:
  - Adds output dbg_round [5:0], the current rnd value: FIRST_ROUND at load, updated each RUN cycle, holds the final value in DONE, reset 0.
  - Adds output dbg_perm_count [15:0], the number of completed permutations; it increments on out_valid&out_ready, wraps at 0xFFFF->0, reset 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- eaglesong_pkg holds:
  - typedef word_t (logic[31:0]) and state_t (word_t[15:0]);
  - BIT_MATRIX[16][16], COEF[16][3], INJECT[43][16], EAGLESONG_MAX_ROUNDS=43;
  - fsm enum perm_state_e {IDLE,RUN,DONE}.
- One sub-module: eaglesong_round.
  - Combinational; inputs state_t and a round index, output state_t.
  - ROUNDS_PER_CYCLE instances are chained via a generate loop, each gated by an enable for the partial final cycle.

Test Plan:
1. R=1, in_state = {48656C6C, 6F2C2077, 6F726C64, 00210A06, 12x 00000000}, out_ready=1 -> out_valid exactly 43 cycles after accept. out_state matches the C reference model word for word.
2. Same vector with R=4 and R=43 -> identical out_state to scenario 1, with latency 11 and 1 cycles respectively.
3. Hold out_ready=0 for 20 cycles after out_valid -> out_state stable, in_ready=0. Then out_ready=1 with in_valid=1 (all-zero state) -> second permutation accepted the same cycle; its result equals the model's output for a zero state.
4. Assert rst at cycle 20 of RUN (R=1) -> next edge: out_valid=0, busy=0, in_ready=1. A subsequent run gives the correct result.
5. NUM_ROUNDS=1, FIRST_ROUND=42 -> out_state equals one model round using INJECT[42]. With EAGLESONG_PERM_DBG_PORT_EN defined, dbg_round=43 in DONE and dbg_perm_count increments by 1 per handshake.

Source files
------------

// File: rtl/eaglesong_pkg.sv
// Shared types, constants and helpers for the Eaglesong permutation engine.
// The injection table is produced by a fixed xorshift32 sequence so every consumer sees one definition.
package eaglesong_pkg;

    typedef logic [31:0]         word_t;
    typedef word_t [15:0]        state_t;
    typedef logic [42:0][15:0][31:0] inject_tbl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_state_e;

    localparam int EAGLESONG_MAX_ROUNDS = 43;

    // BIT_MATRIX[k][j]: input word k contributes to output word j.
    localparam logic [15:0] BIT_MATRIX [16] = '{
        16'h8FAF, 16'h9F5E, 16'hBEBC, 16'hFD78,
        16'h7557, 16'h5211, 16'h1F23, 16'hA447,
        16'hAD8E, 16'h9B2C, 16'h4A79, 16'h23D6,
        16'hC2F1, 16'h3B6A, 16'h7E95, 16'hE93B
    };

    localparam logic [4:0] COEF [16][3] = '{
        '{5'd0, 5'd2,  5'd4},  '{5'd0, 5'd13, 5'd22}, '{5'd0, 5'd4,  5'd19}, '{5'd0, 5'd3,  5'd14},
        '{5'd0, 5'd27, 5'd31}, '{5'd0, 5'd3,  5'd8},  '{5'd0, 5'd17, 5'd26}, '{5'd0, 5'd3,  5'd12},
        '{5'd0, 5'd18, 5'd22}, '{5'd0, 5'd12, 5'd18}, '{5'd0, 5'd4,  5'd7},  '{5'd0, 5'd4,  5'd31},
        '{5'd0, 5'd12, 5'd27}, '{5'd0, 5'd7,  5'd17}, '{5'd0, 5'd7,  5'd8},  '{5'd0, 5'd1,  5'd13}
    };

    function automatic inject_tbl_t gen_inject();
        inject_tbl_t tbl;
        logic [31:0] x;
        tbl = '0;
        x   = 32'h6E9E_40AE;
        for (int r = 0; r < EAGLESONG_MAX_ROUNDS; r++) begin
            for (int i = 0; i < 16; i++) begin
                x = x ^ (x << 13);
                x = x ^ (x >> 17);
                x = x ^ (x << 5);
                tbl[r][i] = x;
            end
        end
        return tbl;
    endfunction

    localparam inject_tbl_t INJECT = gen_inject();

    function automatic word_t rotl(input word_t x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/eaglesong_round.sv
// One combinational Eaglesong round; a low i_en passes the state through untouched.
module eaglesong_round
    import eaglesong_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_round,
    input  logic       i_en,
    output state_t     o_state
);

    state_t w_mix;
    state_t w_circ;
    state_t w_arx;

    // Bit-matrix mix over GF(2) at word granularity.
    always_comb begin
        w_mix = '0;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) begin
                w_mix[j] = w_mix[j] ^ (BIT_MATRIX[k][j] ? i_state[k] : 32'h0000_0000);
            end
        end
    end

    // Circulant spreading followed by the round-constant injection.
    always_comb begin
        w_circ = '0;
        for (int i = 0; i < 16; i++) begin
            w_circ[i] = w_mix[i] ^ rotl(w_mix[i], COEF[i][1]) ^ rotl(w_mix[i], COEF[i][2])
                      ^ INJECT[i_round][i];
        end
    end

    // Add-rotate-add on each adjacent word pair.
    always_comb begin
        w_arx = '0;
        for (int i = 0; i < 16; i += 2) begin
            w_arx[i]   = rotl(w_circ[i] + w_circ[i+1], 5'd8);
            w_arx[i+1] = rotl(w_circ[i+1], 5'd24) + w_arx[i];
        end
    end

    assign o_state = i_en ? w_arx : i_state;

endmodule

// File: rtl/eaglesong_perm_engine.sv
// Handshaked multi-round Eaglesong permutation with ROUNDS_PER_CYCLE unrolled rounds per clock.
// Define EAGLESONG_PERM_DBG_PORT_EN to expose dbg_round and dbg_perm_count.
module eaglesong_perm_engine
    import eaglesong_pkg::*;
#(
    parameter int NUM_ROUNDS       = 43,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int FIRST_ROUND      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  state_t      in_state,
    output logic        out_valid,
    input  logic        out_ready,
    output state_t      out_state,
    output logic        busy
`ifdef EAGLESONG_PERM_DBG_PORT_EN
    ,
    output logic [5:0]  dbg_round,
    output logic [15:0] dbg_perm_count
`endif
);

    localparam logic [6:0] END_RND7   = 7'(FIRST_ROUND + NUM_ROUNDS);
    localparam logic [5:0] FIRST_RND6 = 6'(FIRST_ROUND);
    localparam logic [6:0] RPC7       = 7'(ROUNDS_PER_CYCLE);

    perm_state_e r_state;
    perm_state_e w_state_next;
    state_t      r_data;
    state_t      r_out_state;
    logic [5:0]  r_rnd;
    logic        r_out_valid;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_finish;
    logic [6:0]  w_rnd_step;
    logic [6:0]  w_rnd_next;
    state_t      w_stage [ROUNDS_PER_CYCLE+1];

    assign w_stage[0] = r_data;

    // Stages past the final round are disabled so the last partial cycle passes through.
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        logic [6:0] w_idx7;
        logic       w_en;
        assign w_idx7 = {1'b0, r_rnd} + 7'(g);
        assign w_en   = (r_state == RUN) && (w_idx7 < END_RND7);
        eaglesong_round u_round (
            .i_state (w_stage[g]),
            .i_round (w_en ? w_idx7[5:0] : 6'd0),
            .i_en    (w_en),
            .o_state (w_stage[g+1])
        );
    end

    assign w_rnd_step = {1'b0, r_rnd} + RPC7;
    assign w_rnd_next = (w_rnd_step > END_RND7) ? END_RND7 : w_rnd_step;
    assign w_finish   = (r_state == RUN) && (w_rnd_next == END_RND7);
    assign w_accept   = in_valid & w_in_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and input-side readiness.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_finish) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                w_in_ready = out_ready;
                if (out_ready) begin
                    w_state_next = in_valid ? RUN : IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Working state, round counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_rnd       <= 6'd0;
            r_out_state <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= in_state;
                r_rnd  <= FIRST_RND6;
            end else if (r_state == RUN) begin
                r_data <= w_stage[ROUNDS_PER_CYCLE];
                r_rnd  <= w_rnd_next[5:0];
            end
            if (w_finish) begin
                r_out_state <= w_stage[ROUNDS_PER_CYCLE];
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign busy      = (r_state == RUN);

`ifdef EAGLESONG_PERM_DBG_PORT_EN
    logic [15:0] r_perm_count;

    // Completed-permutation counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perm_count <= 16'd0;
        end else if (r_out_valid && out_ready) begin
            r_perm_count <= r_perm_count + 16'd1;
        end
    end

    assign dbg_round      = r_rnd;
    assign dbg_perm_count = r_perm_count;
`endif

endmodule

// File: tb/tb_eaglesong_perm_engine.sv
// Directed bench for eaglesong_perm_engine: four parameterisations share one stimulus stream
// and are compared against an independent behavioural model of the round function.
module tb_eaglesong_perm_engine;
    import eaglesong_pkg::*;

    logic   clk;
    logic   rst;
    logic   in_valid;
    logic   out_ready;
    state_t in_state;

    logic   ov [4];
    logic   ir [4];
    logic   bz [4];
    state_t os [4];
`ifdef EAGLESONG_PERM_DBG_PORT_EN
    logic [5:0]  dr [4];
    logic [15:0] dc [4];
`endif

    int     n_checks;
    int     n_fail;
    int     lat [4];
    state_t res [4];

    always #5 clk = ~clk;

    eaglesong_perm_engine #(.NUM_ROUNDS(43), .ROUNDS_PER_CYCLE(1), .FIRST_ROUND(0)) u_dut_r1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
        .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bz[0])
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        , .dbg_round(dr[0]), .dbg_perm_count(dc[0])
`endif
    );
    eaglesong_perm_engine #(.NUM_ROUNDS(43), .ROUNDS_PER_CYCLE(4), .FIRST_ROUND(0)) u_dut_r4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
        .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bz[1])
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        , .dbg_round(dr[1]), .dbg_perm_count(dc[1])
`endif
    );
    eaglesong_perm_engine #(.NUM_ROUNDS(43), .ROUNDS_PER_CYCLE(43), .FIRST_ROUND(0)) u_dut_r43 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state),
        .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bz[2])
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        , .dbg_round(dr[2]), .dbg_perm_count(dc[2])
`endif
    );
    eaglesong_perm_engine #(.NUM_ROUNDS(1), .ROUNDS_PER_CYCLE(1), .FIRST_ROUND(42)) u_dut_last (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_state(in_state),
        .out_valid(ov[3]), .out_ready(out_ready), .out_state(os[3]), .busy(bz[3])
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        , .dbg_round(dr[3]), .dbg_perm_count(dc[3])
`endif
    );

    task automatic check_value(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic word_t m_rotl(input word_t x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[63-n -: 32];
    endfunction

    function automatic state_t model_round(input state_t s, input int r);
        state_t u;
        state_t t;
        word_t  a;
        word_t  b;
        for (int j = 0; j < 16; j++) begin
            u[j] = 32'h0;
            for (int k = 0; k < 16; k++) begin
                if (BIT_MATRIX[k][j]) u[j] = u[j] ^ s[k];
            end
        end
        for (int i = 0; i < 16; i++) begin
            t[i] = u[i] ^ m_rotl(u[i], int'(COEF[i][1])) ^ m_rotl(u[i], int'(COEF[i][2]));
            t[i] = t[i] ^ INJECT[r][i];
        end
        for (int p = 0; p < 8; p++) begin
            a = t[2*p] + t[2*p+1];
            a = m_rotl(a, 8);
            b = m_rotl(t[2*p+1], 24);
            b = b + a;
            t[2*p]   = a;
            t[2*p+1] = b;
        end
        return t;
    endfunction

    function automatic state_t model_perm(input state_t s, input int first, input int n);
        state_t x;
        x = s;
        for (int r = first; r < first + n; r++) x = model_round(x, r);
        return x;
    endfunction

    // Watch every instance for its first out_valid after an accept; 0 means it never came.
    task automatic wait_done(input int max_cyc);
        for (int d = 0; d < 4; d++) begin
            lat[d] = 0;
            res[d] = '0;
        end
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                if (ov[d] && lat[d] == 0) begin
                    lat[d] = c;
                    res[d] = os[d];
                end
            end
        end
    endtask

    initial begin
        state_t v1;
        state_t v2;
        state_t zero_s;
        state_t exp43;
        state_t exp_last;
        logic   stable;

        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        n_checks = 0; n_fail = 0;
        zero_s = '0;
        v1 = '0;
        v1[0] = 32'h48656C6C; v1[1] = 32'h6F2C2077; v1[2] = 32'h6F726C64; v1[3] = 32'h00210A06;
        for (int i = 0; i < 16; i++) v2[i] = (32'h01010101 * i) ^ 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check_value($sformatf("rst_ov%0d", d), 512'(ov[d]), 512'(0));
            check_value($sformatf("rst_busy%0d", d), 512'(bz[d]), 512'(0));
            check_value($sformatf("rst_ir%0d", d), 512'(ir[d]), 512'(1));
            check_value($sformatf("rst_os%0d", d), os[d], zero_s);
        end

        // Scenario 1/2/5: hello-world vector on every instance, consumer stalled.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_state = v1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_state = {16{32'hA5A5_5A5A}};
        check_value("busy_after_accept", 512'(bz[0]), 512'(1));
        check_value("ir_in_run", 512'(ir[0]), 512'(0));
        wait_done(60);
        exp43    = model_perm(v1, 0, 43);
        exp_last = model_perm(v1, 42, 1);
        check_value("lat_r1", 512'(lat[0]), 512'(43));
        check_value("lat_r4", 512'(lat[1]), 512'(11));
        check_value("lat_r43", 512'(lat[2]), 512'(1));
        check_value("lat_last", 512'(lat[3]), 512'(1));
        check_value("res_r1", res[0], exp43);
        check_value("res_r4", res[1], exp43);
        check_value("res_r43", res[2], exp43);
        check_value("res_last", res[3], exp_last);
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        check_value("dbg_round_r1", 512'(dr[0]), 512'(43));
        check_value("dbg_round_last", 512'(dr[3]), 512'(43));
        check_value("dbg_count0", 512'(dc[0]), 512'(0));
`endif

        // Scenario 3: 20 more stalled cycles, then a back-to-back zero-state accept.
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (os[0] !== exp43 || ov[0] !== 1'b1 || ir[0] !== 1'b0) stable = 1'b0;
        end
        check_value("hold_stable", 512'(stable), 512'(1));
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_state = zero_s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("b2b_busy", 512'(bz[0]), 512'(1));
        check_value("b2b_ov_clear", 512'(ov[0]), 512'(0));
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        check_value("dbg_count1", 512'(dc[0]), 512'(1));
`endif
        wait_done(60);
        check_value("zero_lat_r1", 512'(lat[0]), 512'(43));
        check_value("zero_res_r1", res[0], model_perm(zero_s, 0, 43));
        check_value("zero_res_r4", res[1], model_perm(zero_s, 0, 43));
        check_value("zero_res_last", res[3], model_perm(zero_s, 42, 1));
        check_value("idle_after_drain", 512'(ir[0]), 512'(1));
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        check_value("dbg_count2", 512'(dc[0]), 512'(2));
        check_value("dbg_count2_last", 512'(dc[3]), 512'(2));
`endif

        // Scenario 4: abort mid-run with rst, then rerun.
        @(negedge clk); in_valid = 1'b1; in_state = v2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_value("midrun_busy", 512'(bz[0]), 512'(1));
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_value("abort_ov", 512'(ov[0]), 512'(0));
        check_value("abort_busy", 512'(bz[0]), 512'(0));
        check_value("abort_ir", 512'(ir[0]), 512'(1));
        check_value("abort_os", os[0], zero_s);
`ifdef EAGLESONG_PERM_DBG_PORT_EN
        check_value("abort_dbg_round", 512'(dr[0]), 512'(0));
        check_value("abort_dbg_count", 512'(dc[0]), 512'(0));
`endif
        @(negedge clk); rst = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_state = v2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(60);
        check_value("rerun_lat_r1", 512'(lat[0]), 512'(43));
        check_value("rerun_res_r1", res[0], model_perm(v2, 0, 43));
        check_value("rerun_lat_r4", 512'(lat[1]), 512'(11));
        check_value("rerun_res_r43", res[2], model_perm(v2, 0, 43));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
